// File: rtl/usb_rx_controller.sv
// Receive-side packet FSM for the full-speed USB endpoint: checks SYNC, decodes the PID,
// counts token/data bytes and streams data-packet bytes (payload + CRC16) into the RX FIFO.
module usb_rx_controller #(
    parameter logic [7:0] SYNC_BYTE      = 8'h80,
    parameter int         MAX_DATA_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       eop,
    input  logic       buffer_full,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       store_rx_data,
    output logic [7:0] rx_data,
    output logic [6:0] rx_byte_count,
    output logic [3:0] rx_state_o
);

    // Handshake: byte_received is a single-cycle valid with no ready; a byte is taken by
    // the FIFO exactly when store_rx_data is high in that same cycle, otherwise it is lost.

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_DATA, S_WAIT_EOP, S_DONE, S_ERR, S_EIDLE
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_DATA_BYTES + 2);

    localparam logic [2:0] PKT_OUT   = 3'd1;
    localparam logic [2:0] PKT_IN    = 3'd2;
    localparam logic [2:0] PKT_DATA0 = 3'd3;
    localparam logic [2:0] PKT_DATA1 = 3'd4;
    localparam logic [2:0] PKT_ACK   = 3'd5;
    localparam logic [2:0] PKT_NAK   = 3'd6;

    state_t     state_q;
    logic [2:0] rx_packet_q;
    logic       rx_data_ready_q;
    logic       rx_transfer_active_q;
    logic       rx_error_q;
    logic [6:0] count_q;
    logic       token_cnt_q;
    logic [2:0] pid_code;
    logic       clean_byte;

    // A byte arriving together with SE0 is never accepted.
    assign clean_byte = byte_received && !eop;

    always_comb begin
        pid_code = 3'd0;
        if (rcv_data[7:4] == ~rcv_data[3:0]) begin
            case (rcv_data[3:0])
                4'b0001: pid_code = PKT_OUT;
                4'b1001: pid_code = PKT_IN;
                4'b0011: pid_code = PKT_DATA0;
                4'b1011: pid_code = PKT_DATA1;
                4'b0010: pid_code = PKT_ACK;
                4'b1010: pid_code = PKT_NAK;
                default: pid_code = 3'd0;
            endcase
        end
    end

    assign store_rx_data = (state_q == S_DATA) && clean_byte && !buffer_full && (count_q < MAX_CNT);
    assign rx_data       = rcv_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q              <= S_IDLE;
            rx_packet_q          <= 3'd0;
            rx_data_ready_q      <= 1'b0;
            rx_transfer_active_q <= 1'b0;
            rx_error_q           <= 1'b0;
            count_q              <= 7'd0;
            token_cnt_q          <= 1'b0;
        end else begin
            rx_data_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (d_edge) begin
                        state_q              <= S_SYNC;
                        rx_error_q           <= 1'b0;
                        rx_packet_q          <= 3'd0;
                        count_q              <= 7'd0;
                        rx_transfer_active_q <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (clean_byte && rcv_data == SYNC_BYTE) begin
                        state_q <= S_PID;
                    end else if (byte_received || eop) begin
                        state_q    <= S_ERR;
                        rx_error_q <= 1'b1;
                    end
                end
                S_PID: begin
                    if (clean_byte && pid_code != 3'd0) begin
                        rx_packet_q <= pid_code;
                        token_cnt_q <= 1'b0;
                        if (pid_code == PKT_OUT || pid_code == PKT_IN) begin
                            state_q <= S_TOKEN;
                        end else if (pid_code == PKT_ACK || pid_code == PKT_NAK) begin
                            state_q <= S_WAIT_EOP;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else if (byte_received || eop) begin
                        state_q    <= S_ERR;
                        rx_error_q <= 1'b1;
                    end
                end
                S_TOKEN: begin
                    if (clean_byte) begin
                        token_cnt_q <= 1'b1;
                        if (token_cnt_q) begin
                            state_q <= S_WAIT_EOP;
                        end
                    end else if (eop) begin
                        state_q    <= S_ERR;
                        rx_error_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (eop && !byte_received && count_q >= 7'd2) begin
                        state_q         <= S_DONE;
                        rx_data_ready_q <= (rx_packet_q == PKT_DATA0) || (rx_packet_q == PKT_DATA1);
                    end else if (store_rx_data) begin
                        count_q <= count_q + 7'd1;
                    end else if (byte_received || eop) begin
                        // Short packet, FIFO full, overflow or byte colliding with SE0.
                        state_q    <= S_ERR;
                        rx_error_q <= 1'b1;
                    end
                end
                S_WAIT_EOP: begin
                    if (byte_received) begin
                        state_q    <= S_ERR;
                        rx_error_q <= 1'b1;
                    end else if (eop) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_EIDLE;
                end
                S_ERR: begin
                    if (eop) begin
                        state_q <= S_EIDLE;
                    end
                end
                S_EIDLE: begin
                    if (!eop) begin
                        state_q              <= S_IDLE;
                        rx_transfer_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_packet          = rx_packet_q;
    assign rx_data_ready      = rx_data_ready_q;
    assign rx_transfer_active = rx_transfer_active_q;
    assign rx_error           = rx_error_q;
    assign rx_byte_count      = count_q;
    assign rx_state_o         = state_q;

endmodule

// File: tb/tb_usb_rx_controller.sv
// Bench for usb_rx_controller: directed packets from the USB packet rules plus random
// packets, each scored against a packet-level reference model and an expected FIFO queue.
module tb_usb_rx_controller;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge, byte_received, eop, buffer_full;
    logic [7:0] rcv_data;
    logic [2:0] rx_packet;
    logic       rx_data_ready, rx_transfer_active, rx_error, store_rx_data;
    logic [7:0] rx_data;
    logic [6:0] rx_byte_count;
    logic [3:0] rx_state_o;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int ready_cnt  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pkt_q[$];
    int         full_idx;
    bit         last_with_eop;

    usb_rx_controller dut (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_received(byte_received),
        .rcv_data(rcv_data), .eop(eop), .buffer_full(buffer_full),
        .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
        .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .store_rx_data(store_rx_data), .rx_data(rx_data),
        .rx_byte_count(rx_byte_count), .rx_state_o(rx_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every FIFO strobe must match the next expected byte.
    always @(negedge clk) begin
        if (store_rx_data) begin
            strobe_cnt++;
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (rx_data_ready) ready_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet-level reference: walk the byte list through the USB receive rules.
    task automatic model(output logic [2:0] ptype, output bit err_pre, output bit err,
                         output int stored, output bit ready);
        int  phase;   // 0 sync, 1 pid, 2 token, 3 handshake, 4 data
        int  tok;
        int  n;
        logic [7:0] b;
        ptype = 3'd0; err_pre = 0; stored = 0; phase = 0; tok = 0;
        n = pkt_q.size();
        for (int i = 0; i < n && !err_pre; i++) begin
            b = pkt_q[i];
            if (last_with_eop && i == n - 1) begin
                err_pre = 1;
            end else begin
                case (phase)
                    0: if (b == 8'h80) phase = 1; else err_pre = 1;
                    1: begin
                        if (b[7:4] != ~b[3:0]) err_pre = 1;
                        else case (b[3:0])
                            4'h1: begin ptype = 3'd1; phase = 2; end
                            4'h9: begin ptype = 3'd2; phase = 2; end
                            4'h3: begin ptype = 3'd3; phase = 4; end
                            4'hB: begin ptype = 3'd4; phase = 4; end
                            4'h2: begin ptype = 3'd5; phase = 3; end
                            4'hA: begin ptype = 3'd6; phase = 3; end
                            default: err_pre = 1;
                        endcase
                    end
                    2: begin tok++; if (tok > 2) err_pre = 1; end
                    3: err_pre = 1;
                    default: begin
                        if (i == full_idx || stored == 66) err_pre = 1;
                        else begin stored++; exp_q.push_back(b); end
                    end
                endcase
            end
        end
        err = err_pre;
        if (!err && (phase < 2 || (phase == 2 && tok < 2) || (phase == 4 && stored < 2))) err = 1;
        ready = !err && phase == 4;
    endtask

    task automatic start_packet();
        strobe_cnt = 0;
        ready_cnt  = 0;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        check("active_after_d_edge", 32'(rx_transfer_active), 32'd1);
        check("error_cleared_by_d_edge", 32'(rx_error), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit full, input bit with_eop);
        repeat ($urandom_range(0, 2)) tick();
        byte_received = 1'b1;
        rcv_data      = b;
        buffer_full   = full;
        if (with_eop) eop = 1'b1;
        tick();
        byte_received = 1'b0;
        buffer_full   = 1'b0;
    endtask

    task automatic end_packet();
        eop = 1'b1;
        tick();
        tick();
        eop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run_packet(input string name);
        logic [2:0] ptype;
        bit err_pre, err, ready;
        int stored;
        model(ptype, err_pre, err, stored, ready);
        start_packet();
        for (int i = 0; i < pkt_q.size(); i++)
            send_byte(pkt_q[i], i == full_idx, last_with_eop && i == pkt_q.size() - 1);
        if (!last_with_eop) begin
            check({name, "_error_before_eop"}, 32'(rx_error), 32'(err_pre));
            check({name, "_active_before_eop"}, 32'(rx_transfer_active), 32'd1);
        end
        end_packet();
        check({name, "_rx_packet"}, 32'(rx_packet), 32'(ptype));
        check({name, "_byte_count"}, 32'(rx_byte_count), 32'(stored));
        check({name, "_rx_error"}, 32'(rx_error), 32'(err));
        check({name, "_active_idle"}, 32'(rx_transfer_active), 32'd0);
        check({name, "_strobes"}, 32'(strobe_cnt), 32'(stored));
        check({name, "_ready_pulses"}, 32'(ready_cnt), 32'(ready));
        check({name, "_exp_q_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        full_idx = -1;
        last_with_eop = 0;
    endtask

    initial begin
        int kind;
        int len;
        n_rst = 1'b0; d_edge = 1'b0; byte_received = 1'b0; eop = 1'b0;
        buffer_full = 1'b0; rcv_data = 8'h00; full_idx = -1; last_with_eop = 0;
        tick();
        check("reset_rx_packet", 32'(rx_packet), 32'd0);
        check("reset_active", 32'(rx_transfer_active), 32'd0);
        check("reset_error", 32'(rx_error), 32'd0);
        check("reset_count", 32'(rx_byte_count), 32'd0);
        check("reset_ready", 32'(rx_data_ready), 32'd0);
        check("reset_store", 32'(store_rx_data), 32'd0);
        n_rst = 1'b1;
        tick();

        pkt_q = '{8'h80, 8'hD2};
        run_packet("ack");
        check("ack_code", 32'(rx_packet), 32'd5);

        pkt_q = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};
        run_packet("data0_5");
        check("data0_count", 32'(rx_byte_count), 32'd5);

        pkt_q = '{8'h80, 8'hC4};
        run_packet("bad_pid");
        check("bad_pid_sticky", 32'(rx_error), 32'd1);

        pkt_q = '{8'h80, 8'hD2};
        run_packet("after_bad_pid");

        pkt_q = '{8'h81};
        run_packet("bad_sync");

        pkt_q.delete();
        run_packet("eop_in_sync");

        pkt_q = '{8'h80, 8'h4B};
        for (int i = 0; i < 67; i++) pkt_q.push_back(8'($urandom));
        run_packet("overflow");
        check("overflow_count", 32'(rx_byte_count), 32'd66);

        pkt_q = '{8'h80, 8'hC3, 8'h5A, 8'hA5, 8'h3C};
        full_idx = 3;
        run_packet("buffer_full");
        check("buffer_full_one_strobe", 32'(strobe_cnt), 32'd1);

        pkt_q = '{8'h80, 8'hE1, 8'h12, 8'h34};
        run_packet("token_out");

        pkt_q = '{8'h80, 8'hE1, 8'h12};
        run_packet("token_short");

        pkt_q = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33};
        last_with_eop = 1;
        run_packet("byte_with_eop");

        pkt_q = '{8'h80, 8'hC3, 8'h11};
        run_packet("data_too_short");

        // Reset mid-DATA: outputs return to zero without waiting for a clock.
        exp_q = '{8'h11, 8'h22};
        start_packet();
        send_byte(8'h80, 0, 0);
        send_byte(8'hC3, 0, 0);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        check("mid_data_packet", 32'(rx_packet), 32'd3);
        check("mid_data_count", 32'(rx_byte_count), 32'd2);
        #1;
        byte_received = 1'b1;
        rcv_data = 8'h00;
        n_rst = 1'b0;
        #2;
        check("rst_mid_packet", 32'(rx_packet), 32'd0);
        check("rst_mid_count", 32'(rx_byte_count), 32'd0);
        check("rst_mid_active", 32'(rx_transfer_active), 32'd0);
        check("rst_mid_error", 32'(rx_error), 32'd0);
        check("rst_mid_store", 32'(store_rx_data), 32'd0);
        byte_received = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
        check("rst_mid_strobes", 32'(strobe_cnt), 32'd2);
        exp_q.delete();

        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 4);
            pkt_q = '{8'h80};
            case (kind)
                0: begin
                    pkt_q.push_back($urandom_range(0, 1) ? 8'hC3 : 8'h4B);
                    len = $urandom_range(0, 68);
                    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
                    if ($urandom_range(0, 3) == 0 && len > 0) full_idx = 2 + $urandom_range(0, len - 1);
                end
                1: begin
                    pkt_q.push_back($urandom_range(0, 1) ? 8'hD2 : 8'h5A);
                    if ($urandom_range(0, 3) == 0) pkt_q.push_back(8'($urandom));
                end
                2: begin
                    pkt_q.push_back($urandom_range(0, 1) ? 8'hE1 : 8'h69);
                    len = $urandom_range(1, 3);
                    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
                end
                3: begin
                    pkt_q.push_back(8'($urandom));
                    len = $urandom_range(0, 3);
                    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
                end
                default: begin
                    pkt_q[0] = 8'($urandom);
                    pkt_q.push_back(8'($urandom));
                end
            endcase
            last_with_eop = ($urandom_range(0, 7) == 0);
            run_packet("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
